// File: rtl/console_pkg.sv
// Shared types and constants for the console UART receive path.
package console_pkg;
    localparam int CONSOLE_BYTE_W      = 8;
    localparam int CLKS_PER_BIT_115200 = 868;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

    typedef struct packed {
        logic                      vld;
        logic [CONSOLE_BYTE_W-1:0] data;
    } rx_byte_t;
endpackage

// File: rtl/console_fifo.sv
// Small synchronous FIFO; a push and a pop in the same cycle both succeed, even when full.
module console_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   gclk,
    input  logic                   grst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_pop, do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: dout is forced to zero while empty.
    always_ff @(posedge gclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/console_uart_rx.sv
// 8N1 UART deserialiser feeding a byte FIFO toward the Wrapper console input.
module console_uart_rx
    import console_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic                      RX,
    output logic [CONSOLE_BYTE_W-1:0] CONSOLE_IN,
    output logic                      CONSOLE_IN_valid,
    input  logic                      CONSOLE_IN_ack,
    output logic                      OVERRUN,
    output logic                      FRAME_ERR,
    input  logic                      ERR_CLR
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(CLKS_PER_BIT - 1);

    logic                      rx_meta, rx_s;
    rx_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                bit_q, bit_d;
    logic [CONSOLE_BYTE_W-1:0] sh_q, sh_d;
    rx_byte_t                  push_q, push_d;
    logic                      frame_set, overrun_set;
    logic                      fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            push_q    <= '0;
            OVERRUN   <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            rx_meta   <= RX;
            rx_s      <= rx_meta;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            push_q    <= push_d;
            // Set beats a same-cycle clear.
            OVERRUN   <= overrun_set | (OVERRUN & ~ERR_CLR);
            FRAME_ERR <= frame_set | (FRAME_ERR & ~ERR_CLR);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        push_d    = '0;
        frame_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_LD;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = FULL_LD;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    sh_d  = {rx_s, sh_q[CONSOLE_BYTE_W-1:1]};
                    cnt_d = FULL_LD;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        push_d.vld  = 1'b1;
                        push_d.data = sh_q;
                        state_d     = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO can still accept the byte if the Wrapper pops in the same cycle.
    assign overrun_set      = push_q.vld && fifo_full && !CONSOLE_IN_ack;
    assign CONSOLE_IN_valid = !fifo_empty;

    console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CONSOLE_BYTE_W)
    ) u_fifo (
        .gclk   (CLK),
        .grst_n (RESETn),
        .push   (push_q.vld),
        .din    (push_q.data),
        .pop    (CONSOLE_IN_ack && (fifo_cnt != '0)),
        .dout   (CONSOLE_IN),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_cnt)
    );
endmodule
